// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out receiver: collects WIDTH strobed bits LSB first and
// presents each finished word on a held register with a VALID/ACK handshake.
module serial_deserializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SI,
  input  logic             SH,
  input  logic             CLR,
  input  logic             ACK,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             OVR,
  output logic             BUSY,
  output logic [CNT_W-1:0] CNT
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] next_word;
  logic             complete;

  // New bit enters at the MSB so the first bit received ends up in bit 0.
  assign next_word = {SI, shreg[WIDTH-1:1]};
  assign complete  = SH && !CLR && (CNT == LAST);
  assign BUSY      = (CNT != '0);

  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg <= '0;
      CNT   <= '0;
      Q     <= '0;
      VALID <= 1'b0;
      OVR   <= 1'b0;
    end else begin
      if (CLR) begin
        shreg <= '0;
        CNT   <= '0;
        OVR   <= 1'b0;
      end else if (SH) begin
        if (CNT == LAST) begin
          Q     <= next_word;
          shreg <= '0;
          CNT   <= '0;
        end else begin
          shreg <= next_word;
          CNT   <= CNT + 1'b1;
        end
      end

      // A completion outranks ACK; an unacknowledged word being replaced is an overrun.
      if (complete) begin
        VALID <= 1'b1;
        if (VALID && !ACK) OVR <= 1'b1;
      end else if (ACK) begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: directed scenarios plus random traffic,
// compared against a queue-based model of the receive protocol.
module tb_serial_deserializer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             SI = 1'b0;
  logic             SH = 1'b0;
  logic             CLR = 1'b0;
  logic             ACK = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             VALID;
  logic             OVR;
  logic             BUSY;
  logic [CNT_W-1:0] CNT;

  int errors = 0;
  int checks = 0;

  // Model state: bits of the partial word, plus the presented word and flags.
  bit q_bits[$];
  int m_q = 0;
  bit m_valid = 1'b0;
  bit m_ovr = 1'b0;

  serial_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .SI(SI), .SH(SH), .CLR(CLR), .ACK(ACK),
    .Q(Q), .VALID(VALID), .OVR(OVR), .BUSY(BUSY), .CNT(CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_bits.delete();
    m_q = 0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic model_edge(input bit si, input bit sh, input bit clr, input bit ack);
    int w;
    if (clr) begin
      q_bits.delete();
      m_ovr = 1'b0;
      if (ack) m_valid = 1'b0;
    end else if (sh) begin
      q_bits.push_back(si);
      if (q_bits.size() == WIDTH) begin
        w = 0;
        foreach (q_bits[i]) w = w + (int'(q_bits[i]) << i);
        if (m_valid && !ack) m_ovr = 1'b1;
        m_q = w;
        m_valid = 1'b1;
        q_bits.delete();
      end else if (ack) begin
        m_valid = 1'b0;
      end
    end else if (ack) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"}, 32'(Q), 32'(m_q));
    check({tag, ".valid"}, 32'(VALID), 32'(m_valid));
    check({tag, ".ovr"}, 32'(OVR), 32'(m_ovr));
    check({tag, ".cnt"}, 32'(CNT), 32'(q_bits.size()));
    check({tag, ".busy"}, 32'(BUSY), 32'(q_bits.size() != 0));
  endtask

  // Drive inputs mid-high phase, let the falling edge act, then compare.
  task automatic step(input bit si, input bit sh, input bit clr, input bit ack, input string tag);
    @(posedge CLK);
    #1;
    SI = si; SH = sh; CLR = clr; ACK = ack;
    @(negedge CLK);
    model_edge(si, sh, clr, ack);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] word, input int gap, input bit ack_last,
                           input string tag);
    for (int i = 0; i < WIDTH; i++) begin
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, tag);
      step(word[i], 1'b1, 1'b0, (i == WIDTH - 1) ? ack_last : 1'b0, tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] w;

    model_reset();
    #2;
    check_all("reset");
    #20;
    RST_N = 1'b1;

    // Basic word: 1,0,1,1 LSB first
    step(1'b1, 1'b1, 1'b0, 1'b0, "basic");
    check("basic.cnt1", 32'(CNT), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, "basic");
    step(1'b1, 1'b1, 1'b0, 1'b0, "basic");
    check("basic.busy3", 32'(BUSY), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, "basic");
    check("basic.q", 32'(Q), 32'hD);
    check("basic.valid", 32'(VALID), 32'd1);
    check("basic.cnt0", 32'(CNT), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, "basic_ack");
    check("basic_ack.valid", 32'(VALID), 32'd0);
    check("basic_ack.q", 32'(Q), 32'hD);

    // Gapped strobes
    send_word(4'h6, 3, 1'b0, "gap");
    check("gap.q", 32'(Q), 32'h6);
    step(1'b0, 1'b0, 1'b0, 1'b1, "gap_ack");

    // Overrun
    send_word(4'hA, 0, 1'b0, "ovr_a");
    send_word(4'h5, 0, 1'b0, "ovr_5");
    check("ovr.q", 32'(Q), 32'h5);
    check("ovr.flag", 32'(OVR), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, "ovr_ack");
    check("ovr_ack.flag", 32'(OVR), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, "ovr_clr");
    check("ovr_clr.flag", 32'(OVR), 32'd0);

    // Completion together with ACK
    send_word(4'h3, 0, 1'b0, "simul_3");
    send_word(4'hC, 0, 1'b1, "simul_c");
    check("simul.q", 32'(Q), 32'hC);
    check("simul.valid", 32'(VALID), 32'd1);
    check("simul.ovr", 32'(OVR), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, "simul_ack");

    // CLR mid-word with SH high
    step(1'b0, 1'b1, 1'b0, 1'b0, "clr");
    step(1'b0, 1'b1, 1'b0, 1'b0, "clr");
    step(1'b1, 1'b1, 1'b1, 1'b0, "clr");
    check("clr.cnt", 32'(CNT), 32'd0);
    send_word(4'hF, 0, 1'b0, "clr_f");
    check("clr.q", 32'(Q), 32'hF);
    step(1'b0, 1'b0, 1'b0, 1'b1, "clr_ack");

    // Async reset mid-word
    send_word(4'h9, 0, 1'b0, "arst_9");
    step(1'b1, 1'b1, 1'b0, 1'b0, "arst");
    step(1'b1, 1'b1, 1'b0, 1'b0, "arst");
    step(1'b1, 1'b1, 1'b0, 1'b0, "arst");
    @(posedge CLK);
    #2;
    SH = 1'b0;
    RST_N = 1'b0;
    model_reset();
    #1;
    check("arst.q", 32'(Q), 32'h0);
    check("arst.valid", 32'(VALID), 32'd0);
    check("arst.cnt", 32'(CNT), 32'd0);
    check("arst.ovr", 32'(OVR), 32'd0);
    check("arst.busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    #1;
    RST_N = 1'b1;
    send_word(4'h2, 0, 1'b0, "arst_2");
    check("arst2.q", 32'(Q), 32'h2);
    check("arst2.valid", 32'(VALID), 32'd1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
